// File: rtl/adc_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_dac_pkg
// Description : Shared types and constants for the ADC->DAC conversion
//               sequencer: command and state encodings, STATUS bit layout.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_dac_pkg;

  // Custom-instruction command codes carried on ci_n
  typedef enum logic [1:0] {
    CMD_STATUS     = 2'd0,
    CMD_SET_PERIOD = 2'd1,
    CMD_ENABLE     = 2'd2,
    CMD_LAST       = 2'd3
  } ci_cmd_e;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_SCALE = 2'd2,
    S_PUSH  = 2'd3
  } seq_state_e;

  // STATUS word layout
  localparam int ST_COUNT_LSB   = 0;
  localparam int ST_ENABLE_BIT  = 4;
  localparam int ST_BUSY_BIT    = 5;
  localparam int ST_TIMEOUT_BIT = 6;
  localparam int ST_MISS_LSB    = 8;
  localparam int ST_OVF_LSB     = 16;

  // Shortest legal sample period and the width of the period register
  localparam int PERIOD_MIN = 4;
  localparam int PERIOD_W   = 24;

  // 8-bit increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_dac_conv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_dac_conv_sequencer_if
// Description : ADC request/ack, DAC valid/ready and Nios II custom-instruction
//               signals of the conversion sequencer. slave = sequencer side,
//               master = environment (ADC, DAC driver, CPU) side.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_dac_conv_sequencer_if #(
  parameter int ADC_W = 12,
  parameter int DAC_W = 8
);
  logic             adc_req;
  logic             adc_ack;
  logic [ADC_W-1:0] adc_data;
  logic             dac_valid;
  logic             dac_ready;
  logic [DAC_W-1:0] dac_data;
  logic             ci_start;
  logic [1:0]       ci_n;
  logic [31:0]      ci_dataa;
  logic             ci_done;
  logic [31:0]      ci_result;

  modport slave (
    output adc_req,  input adc_ack,  input adc_data,
    output dac_valid, input dac_ready, output dac_data,
    input  ci_start, input ci_n, input ci_dataa,
    output ci_done,  output ci_result
  );

  modport master (
    input  adc_req,  output adc_ack,  output adc_data,
    input  dac_valid, output dac_ready, input dac_data,
    output ci_start, output ci_n, output ci_dataa,
    input  ci_done,  input ci_result
  );
endinterface
`default_nettype wire

// File: rtl/adc_dac_scaler.sv
`default_nettype none
// ============================================================================
// Module      : adc_dac_scaler
// Description : Two-stage code scaler: stage 1 multiplies the sample by
//               SCALE_NUM, stage 2 divides by SCALE_DEN (truncating) and
//               saturates to the DAC range. out_valid follows in_valid by 2.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_dac_scaler #(
  parameter int ADC_W     = 12,
  parameter int DAC_W     = 8,
  parameter int SCALE_NUM = 51,
  parameter int SCALE_DEN = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [ADC_W-1:0] in_data,
  output logic             out_valid,
  output logic [DAC_W-1:0] out_code
);
  localparam int PROD_W   = ADC_W + $clog2(SCALE_NUM + 1);
  localparam int CODE_MAX = (1 << DAC_W) - 1;

  logic [PROD_W-1:0] prod_q, prod_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DAC_W-1:0]  code_q, code_d;
  logic              s2_valid_q, s2_valid_d;
  logic [PROD_W-1:0] quot;

  // Multiply on capture, then divide and clamp one cycle later
  always_comb begin
    prod_d     = prod_q;
    s1_valid_d = in_valid;
    if (in_valid) prod_d = PROD_W'(in_data) * PROD_W'(SCALE_NUM);
    quot       = prod_q / PROD_W'(SCALE_DEN);
    s2_valid_d = s1_valid_q;
    code_d     = code_q;
    if (s1_valid_q)
      code_d = (quot > PROD_W'(CODE_MAX)) ? DAC_W'(CODE_MAX) : quot[DAC_W-1:0];
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q     <= '0;
      s1_valid_q <= 1'b0;
      code_q     <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      s1_valid_q <= s1_valid_d;
      code_q     <= code_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_code  = code_q;
endmodule
`default_nettype wire

// File: rtl/adc_dac_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_dac_conv_sequencer
// Description : Periodic ADC capture -> x51/1000 scaling -> output FIFO -> DAC
//               handshake, configured and monitored through a multi-cycle
//               Nios II custom-instruction port.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_dac_conv_sequencer
  import adc_dac_pkg::*;
#(
  parameter int ADC_W       = 12,
  parameter int DAC_W       = 8,
  parameter int SCALE_NUM   = 51,
  parameter int SCALE_DEN   = 1000,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int PERIOD_RST  = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  adc_dac_conv_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  seq_state_e           state_q, state_d;
  logic                 enable_q, enable_d;
  logic [PERIOD_W-1:0]  period_q, period_d, pcnt_q, pcnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 timeout_q, timeout_d, seen_q, seen_d;
  logic [7:0]           miss_q, miss_d, ovf_q, ovf_d;
  logic [DAC_W-1:0]     last_q, last_d;
  logic [DAC_W-1:0]     mem_q [FIFO_DEPTH];
  logic [DAC_W-1:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ci_done_q;
  logic [31:0]          ci_result_q, ci_result_d;

  logic tick, adc_req, ack_take, timeout_hit, push_req, busy;
  logic fifo_full, push, pop, scale_valid, miss_inc, ovf_inc;
  logic status_rd, set_period, set_enable;
  logic [DAC_W-1:0] scale_code;
  logic [31:0] status_word, last_word;
  ci_cmd_e cmd;
  logic unused_dataa;

  assign cmd          = ci_cmd_e'(bus.ci_n);
  assign status_rd    = bus.ci_start && (cmd == CMD_STATUS);
  assign set_period   = bus.ci_start && (cmd == CMD_SET_PERIOD);
  assign set_enable   = bus.ci_start && (cmd == CMD_ENABLE);
  assign unused_dataa = ^bus.ci_dataa[31:PERIOD_W];

  adc_dac_scaler #(
    .ADC_W(ADC_W), .DAC_W(DAC_W), .SCALE_NUM(SCALE_NUM), .SCALE_DEN(SCALE_DEN)
  ) u_scaler (
    .clk(clk), .reset(reset), .in_valid(ack_take), .in_data(bus.adc_data),
    .out_valid(scale_valid), .out_code(scale_code)
  );

  // Period counter: free-runs while enabled, SET_PERIOD clamps and restarts it
  always_comb begin
    enable_d = enable_q;
    period_d = period_q;
    tick     = enable_q && (pcnt_q == period_q - PERIOD_W'(1));
    if (!enable_q || tick) pcnt_d = '0;
    else                   pcnt_d = pcnt_q + PERIOD_W'(1);
    if (set_enable) enable_d = bus.ci_dataa[0];
    if (set_period) begin
      period_d = (bus.ci_dataa[PERIOD_W-1:0] < PERIOD_W'(PERIOD_MIN)) ?
                 PERIOD_W'(PERIOD_MIN) : bus.ci_dataa[PERIOD_W-1:0];
      pcnt_d   = '0;
    end
  end

  // Sequencer next state; the ack wait counter only advances in S_REQ
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (tick) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.adc_ack)                               state_d = S_SCALE;
        else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1))   state_d = S_IDLE;
        else                                           to_cnt_d = to_cnt_q + TO_W'(1);
      end
      S_SCALE: if (scale_valid) state_d = S_PUSH;
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs decoded from the current state
  always_comb begin
    adc_req     = (state_q == S_REQ);
    ack_take    = adc_req && bus.adc_ack;
    timeout_hit = adc_req && !bus.adc_ack && (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));
    push_req    = (state_q == S_PUSH);
    busy        = (state_q != S_IDLE);
  end

  // FIFO pointers/storage; a push on full is dropped, pop on valid&ready
  always_comb begin
    fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    push      = push_req && !fifo_full;
    pop       = (count_q != '0) && bus.dac_ready;
    mem_d     = mem_q;
    if (push) mem_d[wr_q] = scale_code;
    wr_d      = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d      = pop  ? rd_q + PTR_W'(1) : rd_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Sticky flags and saturating counters; an event in the read cycle survives the clear
  always_comb begin
    miss_inc  = tick && busy;
    ovf_inc   = push_req && fifo_full;
    miss_d    = status_rd ? {7'd0, miss_inc} : (miss_inc ? sat_inc8(miss_q) : miss_q);
    ovf_d     = status_rd ? {7'd0, ovf_inc}  : (ovf_inc  ? sat_inc8(ovf_q)  : ovf_q);
    timeout_d = timeout_hit || (timeout_q && !status_rd);
    last_d    = push_req ? scale_code : last_q;
    seen_d    = seen_q || push_req;
  end

  // Custom-instruction result, captured in the start cycle from pre-clear state
  always_comb begin
    status_word = '0;
    status_word[ST_COUNT_LSB +: CNT_W] = count_q;
    status_word[ST_ENABLE_BIT]         = enable_q;
    status_word[ST_BUSY_BIT]           = busy;
    status_word[ST_TIMEOUT_BIT]        = timeout_q;
    status_word[ST_MISS_LSB +: 8]      = miss_q;
    status_word[ST_OVF_LSB +: 8]       = ovf_q;
    last_word = '0;
    last_word[31]          = seen_q;
    last_word[DAC_W-1:0]   = last_q;
    ci_result_d = '0;
    if (bus.ci_start) begin
      case (cmd)
        CMD_STATUS: ci_result_d = status_word;
        CMD_LAST:   ci_result_d = last_word;
        default:    ci_result_d = '0;
      endcase
    end
  end

  // State register for everything above
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      enable_q    <= 1'b0;
      period_q    <= PERIOD_W'(PERIOD_RST);
      pcnt_q      <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      miss_q      <= '0;
      ovf_q       <= '0;
      last_q      <= '0;
      seen_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      ci_done_q   <= 1'b0;
      ci_result_q <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      period_q    <= period_d;
      pcnt_q      <= pcnt_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
      miss_q      <= miss_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
      seen_q      <= seen_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      ci_done_q   <= bus.ci_start;
      ci_result_q <= ci_result_d;
    end
  end

  assign bus.adc_req   = adc_req;
  assign bus.dac_valid = (count_q != '0);
  assign bus.dac_data  = (count_q != '0) ? mem_q[rd_q] : '0;
  assign bus.ci_done   = ci_done_q;
  assign bus.ci_result = ci_result_q;
endmodule
`default_nettype wire
